// File: rtl/zqh_sba_bus_arb_if.sv
// zqh_sba_bus_arb_if: requester, response and fabric-side signals of the SBA bus arbiter
interface zqh_sba_bus_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [MASK_W-1:0] req0_mask;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [MASK_W-1:0] req1_mask;
    logic              rsp0_valid, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              bus_req_valid, bus_req_ready, bus_req_write;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [DATA_W-1:0] bus_req_wdata;
    logic [MASK_W-1:0] bus_req_mask;
    logic              bus_rsp_valid, bus_rsp_err;
    logic [DATA_W-1:0] bus_rsp_rdata;
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_mask,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_mask,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata, rsp1_err,
        output bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_mask,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_mask,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_mask,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata, rsp1_err,
        input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata, bus_req_mask,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );
endinterface

// File: rtl/zqh_sba_bus_arb.sv
// zqh_sba_bus_arb: one-outstanding arbiter sharing a system-bus master between core (0) and debug SBA (1)
module zqh_sba_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023,
    parameter bit RR_EN   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    zqh_sba_bus_arb_if.slave io,
    output logic             busy,
    output logic             owner,
    output logic             timeout_pulse
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    state_t                state;
    logic                  last_owner;
    logic [TW-1:0]         tmo_cnt;
    logic                  grant, win, tmo_fire, done, win_write;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata, fin_rdata;
    logic [DATA_W/8-1:0]   win_mask;
    logic                  fin_err;
    always_comb begin
        grant     = state == IDLE && (io.req0_valid || io.req1_valid);
        win       = io.req0_valid && io.req1_valid ? (RR_EN ? !last_owner : 1'b1) : io.req1_valid;
        win_write = win ? io.req1_write : io.req0_write;
        win_addr  = win ? io.req1_addr  : io.req0_addr;
        win_wdata = win ? io.req1_wdata : io.req0_wdata;
        win_mask  = win ? io.req1_mask  : io.req0_mask;
        // a real response in the firing cycle beats the timeout
        tmo_fire  = TIMEOUT != 0 && tmo_cnt == TMO_LAST && !io.bus_rsp_valid;
        done      = state == RSP && (io.bus_rsp_valid || tmo_fire);
        fin_rdata = io.bus_rsp_valid ? io.bus_rsp_rdata : {DATA_W{1'b0}};
        fin_err   = !io.bus_rsp_valid || io.bus_rsp_err;
    end
    assign io.req0_ready = grant && !win;
    assign io.req1_ready = grant && win;
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            last_owner       <= 1'b1;
            owner            <= 1'b0;
            busy             <= 1'b0;
            timeout_pulse    <= 1'b0;
            tmo_cnt          <= '0;
            io.rsp0_valid    <= 1'b0;
            io.rsp0_rdata    <= '0;
            io.rsp0_err      <= 1'b0;
            io.rsp1_valid    <= 1'b0;
            io.rsp1_rdata    <= '0;
            io.rsp1_err      <= 1'b0;
            io.bus_req_valid <= 1'b0;
            io.bus_req_write <= 1'b0;
            io.bus_req_addr  <= '0;
            io.bus_req_wdata <= '0;
            io.bus_req_mask  <= '0;
        end else begin
            io.rsp0_valid <= done && !owner;
            io.rsp1_valid <= done && owner;
            timeout_pulse <= tmo_fire && state == RSP;
            if (done && !owner) begin
                io.rsp0_rdata <= fin_rdata;
                io.rsp0_err   <= fin_err;
            end
            if (done && owner) begin
                io.rsp1_rdata <= fin_rdata;
                io.rsp1_err   <= fin_err;
            end
            case (state)
                IDLE: if (grant) begin
                    state            <= REQ;
                    busy             <= 1'b1;
                    owner            <= win;
                    last_owner       <= win;
                    io.bus_req_valid <= 1'b1;
                    io.bus_req_write <= win_write;
                    io.bus_req_addr  <= win_addr;
                    io.bus_req_wdata <= win_wdata;
                    io.bus_req_mask  <= win_mask;
                end
                REQ: if (io.bus_req_ready) begin
                    state            <= RSP;
                    io.bus_req_valid <= 1'b0;
                    tmo_cnt          <= '0;
                end
                RSP: begin
                    tmo_cnt <= &tmo_cnt ? tmo_cnt : tmo_cnt + 1'b1;
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zqh_sba_bus_arb.sv
// tb_zqh_sba_bus_arb: directed and random stimulus on a round-robin/TIMEOUT=8 and a fixed-priority/no-timeout arbiter
module tb_zqh_sba_bus_arb;
    typedef struct packed {
        logic        rst, v0, v1, w0, w1;
        logic [31:0] a0, a1;
        logic [63:0] d0, d1;
        logic [7:0]  m0, m1;
        logic        brdy, rv;
        logic [63:0] rdat;
        logic        rerr;
    } in_t;
    // transaction-level view: 0 idle, 1 offered to fabric, 2 awaiting response
    typedef struct {
        int          ph;
        logic        last, own;
        int          waited;
        logic        bw;
        logic [31:0] ba;
        logic [63:0] bd;
        logic [7:0]  bm;
        logic        rv0, rv1, re0, re1, tp;
        logic [63:0] rd0, rd1;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    in_t  cur;
    mdl_t ma, mb;
    int   n_vec = 0, n_err = 0;
    int   gnt_a[$], gnt_b[$];
    logic obs_r0a, obs_r1a, obs_r0b, obs_r1b;
    logic busy_a, owner_a, tp_a, busy_b, owner_b, tp_b;

    zqh_sba_bus_arb_if ifa ();
    zqh_sba_bus_arb_if ifb ();
    assign ifa.req0_valid = cur.v0;   assign ifb.req0_valid = cur.v0;
    assign ifa.req0_write = cur.w0;   assign ifb.req0_write = cur.w0;
    assign ifa.req0_addr  = cur.a0;   assign ifb.req0_addr  = cur.a0;
    assign ifa.req0_wdata = cur.d0;   assign ifb.req0_wdata = cur.d0;
    assign ifa.req0_mask  = cur.m0;   assign ifb.req0_mask  = cur.m0;
    assign ifa.req1_valid = cur.v1;   assign ifb.req1_valid = cur.v1;
    assign ifa.req1_write = cur.w1;   assign ifb.req1_write = cur.w1;
    assign ifa.req1_addr  = cur.a1;   assign ifb.req1_addr  = cur.a1;
    assign ifa.req1_wdata = cur.d1;   assign ifb.req1_wdata = cur.d1;
    assign ifa.req1_mask  = cur.m1;   assign ifb.req1_mask  = cur.m1;
    assign ifa.bus_req_ready = cur.brdy; assign ifb.bus_req_ready = cur.brdy;
    assign ifa.bus_rsp_valid = cur.rv;   assign ifb.bus_rsp_valid = cur.rv;
    assign ifa.bus_rsp_rdata = cur.rdat; assign ifb.bus_rsp_rdata = cur.rdat;
    assign ifa.bus_rsp_err   = cur.rerr; assign ifb.bus_rsp_err   = cur.rerr;

    zqh_sba_bus_arb #(.TIMEOUT(8), .RR_EN(1'b1)) u_rr (
        .clock(clk), .reset(cur.rst), .io(ifa.slave),
        .busy(busy_a), .owner(owner_a), .timeout_pulse(tp_a)
    );
    zqh_sba_bus_arb #(.TIMEOUT(0), .RR_EN(1'b0)) u_fp (
        .clock(clk), .reset(cur.rst), .io(ifb.slave),
        .busy(busy_b), .owner(owner_b), .timeout_pulse(tp_b)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph = 0; m.last = 1'b1; m.own = 1'b0; m.waited = 0;
        m.bw = 1'b0; m.ba = '0; m.bd = '0; m.bm = '0;
        m.rv0 = 1'b0; m.rv1 = 1'b0; m.re0 = 1'b0; m.re1 = 1'b0; m.tp = 1'b0;
        m.rd0 = '0; m.rd1 = '0;
        return m;
    endfunction

    function automatic int winner(mdl_t m, in_t i, bit rr);
        if (m.ph != 0 || !(i.v0 || i.v1)) return -1;
        if (i.v0 && i.v1) return rr ? (m.last ? 0 : 1) : 1;
        return i.v1 ? 1 : 0;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, in_t i, bit rr, int tmo);
        mdl_t n = m;
        int   g = winner(m, i, rr);
        logic timed;
        if (i.rst) return mdl_reset();
        n.rv0 = 1'b0; n.rv1 = 1'b0; n.tp = 1'b0;
        if (g >= 0) begin
            n.ph = 1; n.own = g == 1; n.last = g == 1;
            n.bw = g == 1 ? i.w1 : i.w0;
            n.ba = g == 1 ? i.a1 : i.a0;
            n.bd = g == 1 ? i.d1 : i.d0;
            n.bm = g == 1 ? i.m1 : i.m0;
        end else if (m.ph == 1 && i.brdy) begin
            n.ph = 2; n.waited = 0;
        end else if (m.ph == 2) begin
            timed = !i.rv && tmo != 0 && m.waited == tmo - 1;
            if (i.rv || timed) begin
                n.ph = 0; n.tp = timed;
                if (m.own) begin
                    n.rv1 = 1'b1; n.rd1 = timed ? 64'd0 : i.rdat; n.re1 = timed || i.rerr;
                end else begin
                    n.rv0 = 1'b1; n.rd0 = timed ? 64'd0 : i.rdat; n.re0 = timed || i.rerr;
                end
            end else n.waited = m.waited + 1;
        end
        return n;
    endfunction

    task automatic chk_outs(string p, mdl_t m, logic bsy, logic own, logic tp,
                            logic rv0, logic [63:0] rd0, logic re0,
                            logic rv1, logic [63:0] rd1, logic re1,
                            logic bv, logic bw, logic [31:0] ba, logic [63:0] bd, logic [7:0] bm);
        chk({p, ".busy"}, bsy, m.ph != 0);
        chk({p, ".owner"}, own, m.own);
        chk({p, ".timeout_pulse"}, tp, m.tp);
        chk({p, ".rsp0_valid"}, rv0, m.rv0);
        chk({p, ".rsp0_rdata"}, rd0, m.rd0);
        chk({p, ".rsp0_err"}, re0, m.re0);
        chk({p, ".rsp1_valid"}, rv1, m.rv1);
        chk({p, ".rsp1_rdata"}, rd1, m.rd1);
        chk({p, ".rsp1_err"}, re1, m.re1);
        chk({p, ".bus_req_valid"}, bv, m.ph == 1);
        chk({p, ".bus_req_write"}, bw, m.bw);
        chk({p, ".bus_req_addr"}, ba, m.ba);
        chk({p, ".bus_req_wdata"}, bd, m.bd);
        chk({p, ".bus_req_mask"}, bm, m.bm);
    endtask

    // one clock: inputs already applied; ready sampled before the edge, state after it
    task automatic tick();
        int ga, gb;
        #3;
        ga = winner(ma, cur, 1'b1);
        gb = winner(mb, cur, 1'b0);
        obs_r0a = ifa.req0_ready; obs_r1a = ifa.req1_ready;
        obs_r0b = ifb.req0_ready; obs_r1b = ifb.req1_ready;
        if (obs_r0a || obs_r1a) gnt_a.push_back(int'(obs_r1a));
        if (obs_r0b || obs_r1b) gnt_b.push_back(int'(obs_r1b));
        if (!cur.rst) begin
            chk("rr.req0_ready", obs_r0a, ga == 0);
            chk("rr.req1_ready", obs_r1a, ga == 1);
            chk("fp.req0_ready", obs_r0b, gb == 0);
            chk("fp.req1_ready", obs_r1b, gb == 1);
        end
        @(posedge clk);
        ma = mdl_step(ma, cur, 1'b1, 8);
        mb = mdl_step(mb, cur, 1'b0, 0);
        #1;
        chk_outs("rr", ma, busy_a, owner_a, tp_a, ifa.rsp0_valid, ifa.rsp0_rdata, ifa.rsp0_err,
                 ifa.rsp1_valid, ifa.rsp1_rdata, ifa.rsp1_err, ifa.bus_req_valid, ifa.bus_req_write,
                 ifa.bus_req_addr, ifa.bus_req_wdata, ifa.bus_req_mask);
        chk_outs("fp", mb, busy_b, owner_b, tp_b, ifb.rsp0_valid, ifb.rsp0_rdata, ifb.rsp0_err,
                 ifb.rsp1_valid, ifb.rsp1_rdata, ifb.rsp1_err, ifb.bus_req_valid, ifb.bus_req_write,
                 ifb.bus_req_addr, ifb.bus_req_wdata, ifb.bus_req_mask);
    endtask

    task automatic do_reset();
        cur = '0; cur.rst = 1'b1;
        tick(); tick();
        cur.rst = 1'b0;
    endtask

    task automatic drain();
        cur = '0; cur.brdy = 1'b1; cur.rv = 1'b1;
        repeat (4) tick();
        cur = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '0; ma = mdl_reset(); mb = mdl_reset();
        do_reset();
        chk("rst.busy", busy_a, 0);
        chk("rst.owner", owner_a, 0);
        chk("rst.bus_req_valid", ifa.bus_req_valid, 0);
        chk("rst.rsp0_valid", ifa.rsp0_valid, 0);
        chk("rst.timeout_pulse", tp_a, 0);

        // single read from requester 0
        cur.v0 = 1'b1; cur.a0 = 32'h8000_0000; cur.m0 = 8'hFF;
        tick(); chk("rd.req0_ready", obs_r0a, 1);
        cur.v0 = 1'b0;
        tick(); chk("rd.bus_valid", ifa.bus_req_valid, 1); chk("rd.bus_addr", ifa.bus_req_addr, 32'h8000_0000);
        cur.brdy = 1'b1; tick(); cur.brdy = 1'b0;
        tick();
        cur.rv = 1'b1; cur.rdat = 64'hDEAD_BEEF_0123_4567; tick(); cur.rv = 1'b0;
        chk("rd.rsp0_valid", ifa.rsp0_valid, 1);
        chk("rd.rsp0_rdata", ifa.rsp0_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("rd.rsp0_err", ifa.rsp0_err, 0);
        chk("rd.rsp1_valid", ifa.rsp1_valid, 0);
        tick(); chk("rd.pulse_once", ifa.rsp0_valid, 0);

        // continuous tie for four transactions
        do_reset(); gnt_a.delete(); gnt_b.delete();
        cur.v0 = 1'b1; cur.v1 = 1'b1; cur.brdy = 1'b1; cur.rv = 1'b1;
        cur.a0 = 32'h100; cur.a1 = 32'h200; cur.rdat = {$urandom, $urandom};
        repeat (12) tick();
        chk("tie.rr_count", gnt_a.size(), 4);
        chk("tie.fp_count", gnt_b.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("tie.rr_grant", k < gnt_a.size() ? gnt_a[k] : 9, k % 2);
            chk("tie.fp_grant", k < gnt_b.size() ? gnt_b[k] : 9, 1);
        end

        // write from requester 1 under fabric backpressure
        drain();
        cur.v1 = 1'b1; cur.w1 = 1'b1; cur.a1 = 32'h1000_0040; cur.d1 = 64'h55; cur.m1 = 8'h01;
        tick(); chk("bp.req1_ready", obs_r1a, 1);
        cur.v1 = 1'b0; cur.v0 = 1'b1; cur.a0 = 32'h2000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp.bus_valid", ifa.bus_req_valid, 1);
            chk("bp.bus_write", ifa.bus_req_write, 1);
            chk("bp.bus_addr", ifa.bus_req_addr, 32'h1000_0040);
            chk("bp.bus_wdata", ifa.bus_req_wdata, 64'h55);
            chk("bp.bus_mask", ifa.bus_req_mask, 8'h01);
            chk("bp.req0_ready", obs_r0a, 0);
        end
        cur.brdy = 1'b1; tick(); cur.brdy = 1'b0; chk("bp.req0_ready_hs", obs_r0a, 0);
        cur.rv = 1'b1; cur.rdat = 64'h0; tick(); cur.rv = 1'b0;
        chk("bp.rsp1_valid", ifa.rsp1_valid, 1);
        chk("bp.rsp1_err", ifa.rsp1_err, 0);
        tick(); chk("bp.req0_late_grant", obs_r0a, 1);

        // timeout with a stray late response
        drain();
        cur.v0 = 1'b1; cur.a0 = 32'h3000; tick();
        cur.v0 = 1'b0; cur.brdy = 1'b1; tick(); cur.brdy = 1'b0;
        repeat (7) tick();
        chk("tmo.early", tp_a, 0);
        tick();
        chk("tmo.pulse", tp_a, 1);
        chk("tmo.rsp0_valid", ifa.rsp0_valid, 1);
        chk("tmo.rsp0_err", ifa.rsp0_err, 1);
        chk("tmo.rsp0_rdata", ifa.rsp0_rdata, 0);
        repeat (3) tick();
        cur.rv = 1'b1; cur.rdat = 64'h1111_2222_3333_4444; tick(); cur.rv = 1'b0;
        chk("tmo.stray_rsp0", ifa.rsp0_valid, 0);
        chk("tmo.stray_rdata", ifa.rsp0_rdata, 0);
        chk("tmo.stray_busy", busy_a, 0);

        // response lands on the cycle the timeout would fire
        drain();
        cur.v1 = 1'b1; cur.a1 = 32'h4000; tick();
        cur.v1 = 1'b0; cur.brdy = 1'b1; tick(); cur.brdy = 1'b0;
        repeat (7) tick();
        cur.rv = 1'b1; cur.rdat = 64'hA5A5_0000_1234_5678; tick(); cur.rv = 1'b0;
        chk("edge.no_pulse", tp_a, 0);
        chk("edge.rsp1_valid", ifa.rsp1_valid, 1);
        chk("edge.rsp1_rdata", ifa.rsp1_rdata, 64'hA5A5_0000_1234_5678);
        chk("edge.rsp1_err", ifa.rsp1_err, 0);

        // reset while waiting for a response
        drain();
        cur.v0 = 1'b1; tick();
        cur.v0 = 1'b0; cur.brdy = 1'b1; tick(); cur.brdy = 1'b0;
        tick(); tick();
        cur.rst = 1'b1; tick(); cur.rst = 1'b0;
        cur.rv = 1'b1; tick(); cur.rv = 1'b0;
        chk("mrst.rsp0_valid", ifa.rsp0_valid, 0);
        chk("mrst.busy", busy_a, 0);
        cur.v0 = 1'b1; cur.v1 = 1'b1; tick();
        chk("mrst.tie_req0", obs_r0a, 1);
        drain();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cur.rst  = 1'($urandom_range(0, 199) == 0);
            cur.v0   = 1'($urandom_range(0, 1));
            cur.v1   = 1'($urandom_range(0, 1));
            cur.w0   = 1'($urandom_range(0, 1));
            cur.w1   = 1'($urandom_range(0, 1));
            cur.a0   = $urandom; cur.a1 = $urandom;
            cur.d0   = {$urandom, $urandom}; cur.d1 = {$urandom, $urandom};
            cur.m0   = 8'($urandom); cur.m1 = 8'($urandom);
            cur.brdy = 1'($urandom_range(0, 1));
            cur.rv   = 1'($urandom_range(0, 6) == 0);
            cur.rdat = {$urandom, $urandom};
            cur.rerr = 1'($urandom_range(0, 3) == 0);
            tick();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/zqh_sba_bus_arb.md
# zqh_sba_bus_arb

Two-requester arbiter sharing one system-bus master port between the core data port (requester 0) and the JTAG debug system-bus-access (SBA) engine (requester 1). One transaction outstanding at a time. Requests carry a single beat; responses are routed back to the requester that issued them. A response timeout guarantees the debug path never hangs on a dead slave. Sits between the core/debug-module request ports and the system-bus fabric.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; mask width = DATA_W/8
- TIMEOUT, 1023, max cycles waiting for a bus response; 0 disables the timeout
- RR_EN, 1, 1 = round-robin on a tie; 0 = fixed priority, requester 1 wins
- clock  in  1  single clock; everything is sampled on its rising edge
- reset  in  1  synchronous, active-high
- req0_valid/req1_valid  in  1  request pending
- req0_ready/req1_ready  out  1  request accepted this cycle
- req{i}_write  in  1  1 = write
- req{i}_addr  in  ADDR_W  address
- req{i}_wdata  in  DATA_W  write data
- req{i}_mask  in  DATA_W/8  byte enables
- rsp{i}_valid  out  1  one-cycle response pulse; no backpressure
- rsp{i}_rdata  out  DATA_W  read data
- rsp{i}_err  out  1  bus error or timeout
- bus_req_valid  out  1  request to fabric
- bus_req_ready  in  1  fabric accepts
- bus_req_write/addr/wdata/mask  out  as above; registered copy of the granted request
- bus_rsp_valid  in  1  fabric response
- bus_rsp_rdata  in  DATA_W  response data
- bus_rsp_err  in  1  response error
- busy  out  1  state != IDLE
- owner  out  1  index of the current or most recent grantee
- timeout_pulse  out  1  one-cycle pulse when a timeout fires

## Operation
- **FSM states:** IDLE, REQ, RSP.
- **IDLE**
  - Arbitrate combinationally among valid requesters.
  - Single requester valid: it wins.
  - Both valid, RR_EN=1: the requester that is not `last_owner` wins.
  - Both valid, RR_EN=0: requester 1 wins.
  - The winner's `req_ready` is 1 in the same cycle (the loser's is 0). The request is captured into bus registers, `owner`/`last_owner` are set to the winner, and the FSM goes to REQ.
  - `req_ready` is 0 in every state other than IDLE.
- **REQ**
  - `bus_req_valid`=1 and all bus fields stay stable until `bus_req_ready`=1.
  - On that handshake: go to RSP and clear `tmo_cnt`.
  - `bus_rsp_valid` in REQ is ignored.
- **RSP**
  - `tmo_cnt` increments each cycle. Width is clog2(TIMEOUT+1); it saturates and does not wrap.
  - On `bus_rsp_valid`:
    - Register `rdata`/`err` into `rsp{owner}`.
    - Pulse `rsp{owner}_valid` in the next cycle.
    - Go to IDLE.
  - Timeout case: TIMEOUT≠0, `tmo_cnt`==TIMEOUT−1, and no `bus_rsp_valid` this cycle.
    - Complete with `rsp_err`=1 and `rdata`=0.
    - `timeout_pulse`=1 in the next cycle.
    - Go to IDLE.
  - If `bus_rsp_valid` arrives in the same cycle the timeout would fire, the real response wins and there is no timeout.
- A late `bus_rsp_valid` that arrives in IDLE, or in REQ of a later transaction, is dropped.
- `rsp{i}_rdata`/`rsp{i}_err` hold their last value between pulses. The non-owner's `rsp_valid` is always 0.

## Timing
- Reset values:
  - state=IDLE, `last_owner`=1 (so requester 0 wins the first tie), `owner`=0.
  - All `rsp_valid`, `rsp_rdata`, `rsp_err`, `bus_req_*`, `busy`, `timeout_pulse` = 0; `tmo_cnt`=0.
- Request accepted at cycle T → `bus_req_valid` high from T+1.
- `bus_req_ready` at cycle R → RSP from R+1. The earliest honoured `bus_rsp_valid` is R+1.
- `bus_rsp_valid` at cycle X → `rsp_valid` at X+1, FSM in IDLE at X+1. A new grant is possible at X+1, the same cycle as the response pulse.
- Minimum turnaround per transaction: 3 cycles (grant, bus handshake, response).
- Timeout fires TIMEOUT cycles after entering RSP; the pulse appears one cycle after that.
- Reset asserted in any state returns to reset values at the next edge. The in-flight transaction is abandoned with no `rsp_valid`. A response arriving after reset is dropped.

## Test plan
- **Single read, requester 0:** addr 0x8000_0000, `bus_req_ready` 1 cycle after `bus_req_valid`, response rdata 0xDEAD_BEEF_0123_4567 two cycles later → `req0_ready` at T, `rsp0_valid` one cycle after the bus response with the same data, `err`=0, `rsp1_valid` never set.
- **Tie, RR_EN=1:** both requesters valid continuously for 4 transactions → grants 0,1,0,1. **RR_EN=0:** same stimulus → grants 1,1,1,1.
- **Write backpressure:** requester 1 writes 0x55 with mask 0x01 and `bus_req_ready` held low 5 cycles → `bus_req_*` stable all 5 cycles; a new `req0_valid` gets `req0_ready`=0 throughout.
- **Timeout:** TIMEOUT=8, no bus response → `rsp{owner}_valid` with `err`=1, `rdata`=0 and `timeout_pulse` 9 cycles after entering RSP. A stray `bus_rsp_valid` 3 cycles later is ignored.
- **Response on the timeout-fire cycle:** `bus_rsp_valid` in the RSP cycle where `tmo_cnt`=TIMEOUT−1 → normal response delivered, no `timeout_pulse`.
- **Reset mid-transaction:** reset in RSP, then `bus_rsp_valid` → no `rsp_valid`; `busy`=0. The next tie is granted to requester 0.
